// File: rtl/fetch_ctrl_pkg.sv
// Shared MIPS fetch constants, fetch exception codes and the next-PC source encoding.
package mips_defs;

    localparam logic [31:0] PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam int          IM_WORDS   = 4096;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_HOLD = 3'd2,
        SEL_ERET = 3'd3,
        SEL_EXC  = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-ROM bus: fetch drives the byte address, ROM answers combinationally.
interface fetch_ctrl_if;
    logic [31:0] im_addr;
    logic [31:0] im_data;

    modport master (output im_addr, input im_data);
    modport slave  (input im_addr, output im_data);
endinterface

// File: rtl/fetch_ctrl_addr_chk.sv
// Combinational fetch-address check: misaligned or outside the ROM window raises fault.
module fetch_addr_chk #(
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic [31:0] pc,
    output logic        fault
);
    // 33-bit end bound so a window touching 2^32 cannot wrap to zero.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    always_comb begin
        fault = 1'b0;
        if (pc[1:0] != 2'b00)            fault = 1'b1;
        if (pc < IM_BASE)                fault = 1'b1;
        if ({1'b0, pc} >= IM_END)        fault = 1'b1;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// F-stage PC sequencer with IF/ID pipeline register, redirect priority and AdEL tagging.
module fetch_ctrl
    import mips_defs::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         br_taken,
    input  logic [31:0]  br_target,
    input  logic         jump_d,
    input  logic         exc_req,
    input  logic         eret,
    input  logic [31:0]  epc,
    fetch_ctrl_if.master rom,
    output logic [31:0]  pc_f,
    output logic [31:0]  instr_d,
    output logic [31:0]  pc_d,
    output logic [31:0]  pc8_d,
    output logic         valid_d,
    output logic         bd_d,
    output logic [4:0]   exc_code_d,
    output logic [31:0]  fetch_cnt
);
    logic    fault;
    pc_sel_e sel;

    assign rom.im_addr = pc_f;

    fetch_addr_chk #(
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) u_addr_chk (
        .pc    (pc_f),
        .fault (fault)
    );

    always_comb begin
        sel = SEL_SEQ;
        if (exc_req)       sel = SEL_EXC;
        else if (eret)     sel = SEL_ERET;
        else if (stall)    sel = SEL_HOLD;
        else if (br_taken) sel = SEL_BR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f       <= PC_RESET;
            instr_d    <= 32'd0;
            pc_d       <= 32'd0;
            pc8_d      <= 32'd8;
            valid_d    <= 1'b0;
            bd_d       <= 1'b0;
            exc_code_d <= EXC_NONE;
            fetch_cnt  <= 32'd0;
        end else begin
            case (sel)
                SEL_EXC, SEL_ERET: begin
                    pc_f       <= (sel == SEL_EXC) ? EXC_VECTOR : epc;
                    pc_d       <= (sel == SEL_EXC) ? EXC_VECTOR : epc;
                    pc8_d      <= ((sel == SEL_EXC) ? EXC_VECTOR : epc) + 32'd8;
                    instr_d    <= 32'd0;
                    valid_d    <= 1'b0;
                    bd_d       <= 1'b0;
                    exc_code_d <= EXC_NONE;
                end
                SEL_HOLD: begin
                end
                default: begin
                    // The F-stage word is loaded on both sequential and branch
                    // edges; on a branch it is the delay slot.
                    pc_f    <= (sel == SEL_BR) ? br_target : pc_f + 32'd4;
                    pc_d    <= pc_f;
                    pc8_d   <= pc_f + 32'd8;
                    valid_d <= 1'b1;
                    bd_d    <= jump_d;
                    if (fault) begin
                        instr_d    <= 32'd0;
                        exc_code_d <= EXC_ADEL;
                    end else begin
                        instr_d    <= rom.im_data;
                        exc_code_d <= EXC_NONE;
                        fetch_cnt  <= fetch_cnt + 32'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, sequential fetch, stall, delay slot,
// AdEL boundaries, exception/eret redirect and reset during stall.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset, stall, br_taken, jump_d, exc_req, eret;
    logic [31:0] br_target, epc;
    logic [31:0] pc_f, instr_d, pc_d, pc8_d, fetch_cnt;
    logic        valid_d, bd_d;
    logic [4:0]  exc_code_d;

    int checks = 0;
    int errors = 0;

    fetch_ctrl_if bus ();

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[15:0]};
    endfunction

    assign bus.im_data = rom_word(bus.im_addr);

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jump_d     (jump_d),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc        (epc),
        .rom        (bus.master),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc8_d      (pc8_d),
        .valid_d    (valid_d),
        .bd_d       (bd_d),
        .exc_code_d (exc_code_d),
        .fetch_cnt  (fetch_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pc_f"},     pc_f,              32'h0000_3000);
        check({tag, " im_addr"},  bus.im_addr,       32'h0000_3000);
        check({tag, " instr_d"},  instr_d,           32'd0);
        check({tag, " pc_d"},     pc_d,              32'd0);
        check({tag, " pc8_d"},    pc8_d,             32'd8);
        check({tag, " valid_d"},  32'(valid_d),      32'd0);
        check({tag, " bd_d"},     32'(bd_d),         32'd0);
        check({tag, " exc_code"}, 32'(exc_code_d),   32'd0);
        check({tag, " cnt"},      fetch_cnt,         32'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; jump_d = 1'b0;
        exc_req = 1'b0; eret = 1'b0; br_target = 32'd0; epc = 32'd0;

        step(); step();
        check_reset_state("reset");
        reset = 1'b0;

        step(); step(); step();
        check("seq pc_f",    pc_f,         32'h0000_300C);
        check("seq pc_d",    pc_d,         32'h0000_3008);
        check("seq pc8_d",   pc8_d,        32'h0000_3010);
        check("seq instr_d", instr_d,      rom_word(32'h0000_3008));
        check("seq valid_d", 32'(valid_d), 32'd1);
        check("seq cnt",     fetch_cnt,    32'd3);

        step();
        check("pre-stall pc_f", pc_f, 32'h0000_3010);
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_3400;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall pc_f",    pc_f,      32'h0000_3010);
            check("stall instr_d", instr_d,   rom_word(32'h0000_300C));
            check("stall cnt",     fetch_cnt, 32'd4);
        end
        stall = 1'b0; br_taken = 1'b0;
        step();
        check("unstall pc_f", pc_f,      32'h0000_3014);
        check("unstall cnt",  fetch_cnt, 32'd5);

        step(); step(); step();
        check("at 3020 pc_f", pc_f, 32'h0000_3020);
        jump_d = 1'b1; br_taken = 1'b1; br_target = 32'h0000_3100;
        step();
        check("br pc_f",    pc_f,      32'h0000_3100);
        check("br pc_d",    pc_d,      32'h0000_3020);
        check("br bd_d",    32'(bd_d), 32'd1);
        check("br instr_d", instr_d,   rom_word(32'h0000_3020));
        jump_d = 1'b0; br_taken = 1'b0;
        step();
        check("slot bd_d", 32'(bd_d), 32'd0);
        check("slot pc_d", pc_d,      32'h0000_3100);
        check("slot cnt",  fetch_cnt, 32'd10);

        // Misaligned target.
        br_taken = 1'b1; br_target = 32'h0000_3102;
        step();
        br_taken = 1'b0;
        check("mis pc_f", pc_f, 32'h0000_3102);
        check("mis cnt0", fetch_cnt, 32'd11);
        step();
        check("mis exc_code", 32'(exc_code_d), 32'd4);
        check("mis instr_d",  instr_d,         32'd0);
        check("mis valid_d",  32'(valid_d),    32'd1);
        check("mis cnt",      fetch_cnt,       32'd11);
        check("mis pc_f+4",   pc_f,            32'h0000_3106);

        // Below ROM base.
        br_taken = 1'b1; br_target = 32'h0000_2FFC;
        step();
        br_taken = 1'b0;
        step();
        check("low pc_d",     pc_d,            32'h0000_2FFC);
        check("low exc_code", 32'(exc_code_d), 32'd4);
        check("low cnt",      fetch_cnt,       32'd11);
        step();
        check("base exc_code", 32'(exc_code_d), 32'd0);
        check("base instr_d",  instr_d,         rom_word(32'h0000_3000));
        check("base cnt",      fetch_cnt,       32'd12);

        // One past the last ROM word, then the last word itself.
        br_taken = 1'b1; br_target = 32'h0000_7000;
        step();
        br_taken = 1'b0;
        step();
        check("high exc_code", 32'(exc_code_d), 32'd4);
        check("high cnt",      fetch_cnt,       32'd13);
        br_taken = 1'b1; br_target = 32'h0000_6FFC;
        step();
        br_taken = 1'b0;
        step();
        check("last exc_code", 32'(exc_code_d), 32'd0);
        check("last instr_d",  instr_d,         rom_word(32'h0000_6FFC));
        check("last cnt",      fetch_cnt,       32'd14);

        // exc_req beats stall and eret.
        exc_req = 1'b1; stall = 1'b1; eret = 1'b1; epc = 32'h0000_3040;
        step();
        exc_req = 1'b0; stall = 1'b0; eret = 1'b0;
        check("exc pc_f",    pc_f,         32'h0000_4180);
        check("exc valid_d", 32'(valid_d), 32'd0);
        check("exc instr_d", instr_d,      32'd0);
        check("exc pc_d",    pc_d,         32'h0000_4180);
        check("exc cnt",     fetch_cnt,    32'd14);

        eret = 1'b1; epc = 32'h0000_3040;
        step();
        eret = 1'b0;
        check("eret pc_f",    pc_f,            32'h0000_3040);
        check("eret pc_d",    pc_d,            32'h0000_3040);
        check("eret valid_d", 32'(valid_d),    32'd0);
        check("eret instr_d", instr_d,         32'd0);
        check("eret exc",     32'(exc_code_d), 32'd0);

        // Reset in the middle of a stall.
        br_taken = 1'b1; br_target = 32'h0000_3200; jump_d = 1'b1;
        step();
        br_taken = 1'b0;
        stall = 1'b1;
        step();
        check("stall2 pc_f", pc_f, 32'h0000_3200);
        reset = 1'b1;
        step();
        check_reset_state("mid-stall reset");
        reset = 1'b0; stall = 1'b0; jump_d = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
